smul_sequencer: RTL and testbench



---
 rtl/smul_sequencer_pkg.sv | 15 +
 rtl/smul_sequencer_shift_add_core.sv | 35 +++
 rtl/smul_sequencer.sv | 80 ++++++++
 tb/tb_smul_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/smul_sequencer_pkg.sv
// smul_sequencer_pkg: shared SMUL opcode, sequencer state encodings, step count and magnitude helper.
package smul_sequencer_pkg;
  localparam logic [5:0] SMUL = 6'h1c;
  localparam int SMUL_STEPS = 16;
  typedef enum logic [2:0] {
    SMUL_IDLE = 3'd0,
    SMUL_RUN  = 3'd1,
    SMUL_SIGN = 3'd2,
    SMUL_WRLO = 3'd3,
    SMUL_WRHI = 3'd4
  } smul_state_t;
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? 16'(-v) : v;
  endfunction
endpackage

// File: rtl/smul_sequencer_shift_add_core.sv
// smul_shift_add_core: unsigned shift-add multiplier datapath with final two's-complement negation.
module smul_shift_add_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        negate,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic [31:0] product
);
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [15:0] mplier;
  logic [16:0] sum;
  // The low product half shares its register with the multiplier as it shifts out.
  assign sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : 17'd0);
  assign product = {acc, mplier};
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
    end else if (load) begin
      mcand <= multiplicand;
      acc <= '0;
      mplier <= multiplier;
    end else if (step) begin
      acc <= sum[16:1];
      mplier <= {sum[0], mplier[15:1]};
    end else if (negate) begin
      {acc, mplier} <= -{acc, mplier};
    end
  end
endmodule

// File: rtl/smul_sequencer.sv
// smul_sequencer: multi-cycle signed 16x16 multiply sequencer driving the RAM write port.
// Define SMUL_HIGH_WRITE_EN to also write the high product half to dest+1.
module smul_sequencer
  import smul_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  input  logic [7:0]  destination,
  output logic        stall,
  output logic        busy,
  output logic        write_enable,
  output logic [7:0]  write_address,
  output logic [15:0] write_data,
  output logic        done
);
  smul_state_t state, next_state;
  logic [3:0] count;
  logic neg;
  logic [7:0] dest;
  logic [31:0] product;
  logic load;
  assign load = (state == SMUL_IDLE) && start;
  smul_shift_add_core core (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(state == SMUL_RUN),
    .negate((state == SMUL_SIGN) && neg),
    .multiplicand(abs16(operand_a)),
    .multiplier(abs16(operand_b)),
    .product(product)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SMUL_IDLE;
      count <= '0;
      neg <= 1'b0;
      dest <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        count <= '0;
        neg <= operand_a[15] ^ operand_b[15];
        dest <= destination;
      end else if (state == SMUL_RUN) begin
        count <= count + 4'd1;
      end
    end
  end
  always_comb begin
    next_state = state;
    case (state)
      SMUL_IDLE: next_state = start ? SMUL_RUN : SMUL_IDLE;
      SMUL_RUN:  next_state = (count == 4'(SMUL_STEPS - 1)) ? SMUL_SIGN : SMUL_RUN;
      SMUL_SIGN: next_state = SMUL_WRLO;
`ifdef SMUL_HIGH_WRITE_EN
      SMUL_WRLO: next_state = SMUL_WRHI;
`else
      SMUL_WRLO: next_state = SMUL_IDLE;
`endif
      SMUL_WRHI: next_state = SMUL_IDLE;
      default:   next_state = SMUL_IDLE;
    endcase
  end
  always_comb begin
    busy = state != SMUL_IDLE;
    stall = start | busy;
    write_enable = (state == SMUL_WRLO) || (state == SMUL_WRHI);
    write_address = (state == SMUL_WRLO) ? dest : (state == SMUL_WRHI) ? dest + 8'd1 : 8'd0;
    write_data = (state == SMUL_WRLO) ? product[15:0] : (state == SMUL_WRHI) ? product[31:16] : 16'd0;
`ifdef SMUL_HIGH_WRITE_EN
    done = state == SMUL_WRHI;
`else
    done = state == SMUL_WRLO;
`endif
  end
endmodule

// File: tb/tb_smul_sequencer.sv
// tb_smul_sequencer: cycle-timeline reference model with per-cycle compare plus directed literal checks.
module tb_smul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic [7:0] destination = '0;
  logic stall, busy, write_enable, done;
  logic [7:0] write_address;
  logic [15:0] write_data;
  int total = 0;
  int bad = 0;
`ifdef SMUL_HIGH_WRITE_EN
  localparam int LAST = 19;
`else
  localparam int LAST = 18;
`endif
  int t = -1;
  int ma, mb;
  logic [31:0] exp_p = '0;
  logic [7:0] exp_dest = '0;
  logic [15:0] mem [256];
  int writes = 0;

  always #5 clk = ~clk;

  smul_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .destination(destination),
    .stall(stall),
    .busy(busy),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_data(write_data),
    .done(done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: t counts cycles since the accepted start edge; -1 means idle.
  always @(posedge clk) begin
    if (rst) t = -1;
    else if (t < 0) begin
      if (start) begin
        t = 1;
        ma = int'($signed(operand_a));
        mb = int'($signed(operand_b));
        exp_p = 32'(ma * mb);
        exp_dest = destination;
      end
    end else t = (t == LAST) ? -1 : t + 1;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hdead;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      check("busy", busy, t >= 1);
      check("stall", stall, start | (t >= 1));
      check("we", write_enable, t >= 18);
      check("addr", write_address, t == 18 ? exp_dest : t == 19 ? exp_dest + 8'd1 : 8'd0);
      check("data", write_data, t == 18 ? exp_p[15:0] : t == 19 ? exp_p[31:16] : 16'd0);
      check("done", done, t == LAST);
      if (write_enable === 1'b1) begin
        mem[write_address] = write_data;
        writes++;
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      #3;
      lat++;
    end
    check("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [7:0] d, output int lat);
    @(negedge clk);
    start = 1'b1;
    operand_a = a;
    operand_b = b;
    destination = d;
    @(negedge clk);
    start = 1'b0;
    #3;
    wait_done(lat);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 6))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h8000;
      3: return 16'h7fff;
      4: return 16'hffff;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat, w0;
    repeat (3) @(negedge clk);
    check("reset_outs", {stall, busy, write_enable, done, write_address, write_data}, 0);
    rst = 1'b0;
    run_op(16'd3, 16'd4, 8'h10, lat);
    check("lat_3x4", lat, LAST);
    check("lo_3x4", mem[8'h10], 16'h000c);
`ifdef SMUL_HIGH_WRITE_EN
    check("hi_3x4", mem[8'h11], 16'h0000);
`endif
    run_op(16'hfffe, 16'd3, 8'h20, lat);
    check("lo_m2x3", mem[8'h20], 16'hfffa);
`ifdef SMUL_HIGH_WRITE_EN
    check("hi_m2x3", mem[8'h21], 16'hffff);
`endif
    run_op(16'h8000, 16'h8000, 8'h30, lat);
    check("lo_min", mem[8'h30], 16'h0000);
`ifdef SMUL_HIGH_WRITE_EN
    check("hi_min", mem[8'h31], 16'h4000);
`endif
    run_op(16'h7fff, 16'h7fff, 8'hff, lat);
    check("lo_max", mem[8'hff], 16'h0001);
`ifdef SMUL_HIGH_WRITE_EN
    check("hi_wrap", mem[8'h00], 16'h3fff);
`endif
    @(negedge clk);
    start = 1'b1;
    operand_a = 16'd7;
    operand_b = 16'd9;
    destination = 8'h40;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    w0 = writes;
    #3;
    check("rst_outs", {stall, busy, write_enable, done, write_address, write_data}, 0);
    repeat (15) @(negedge clk);
    check("rst_nowrite", writes - w0, 0);
    check("rst_mem", mem[8'h40], 16'hdead);
    run_op(16'd5, 16'd5, 8'h41, lat);
    check("lo_5x5", mem[8'h41], 16'h0019);
    w0 = writes;
    @(negedge clk);
    start = 1'b1;
    operand_a = 16'h0123;
    operand_b = 16'hff00;
    destination = 8'h50;
    repeat (21) @(negedge clk);
    start = 1'b0;
    #3;
    check("held_writes", writes - w0, LAST - 17);
    check("held_restart", busy, 1'b1);
    wait_done(lat);
    check("held_total", writes - w0, 2 * (LAST - 17));
    check("lo_held", mem[8'h50], 16'hdd00);
`ifdef SMUL_HIGH_WRITE_EN
    check("hi_held", mem[8'h51], 16'hfffe);
`endif
    for (int i = 0; i < 40; i++) begin
      run_op(pick(), pick(), 8'($urandom), lat);
      check("lat_rand", lat, LAST);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
